ibex_fetch_req_ctrl: RTL and testbench
======================================

Name: ibex_fetch_req_ctrl

Overview:
Sequencing controller for the instruction fetch path. Issues word-aligned requests on the instruction bus (req/gnt, then in-order rvalid), tracks up to NUM_REQS outstanding transactions and throttles against fetch-FIFO occupancy. Forwards non-discarded responses as FIFO pushes, and clears the FIFO with the branch target on branches. Sits between the IF-stage control and the fetch FIFO / instruction memory port.

Parameters:
NUM_REQS, 2, max outstanding bus transactions; must equal the fetch FIFO's NUM_REQS (range 1..4)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
req_i  in  1  fetch enable from IF stage
branch_i  in  1  redirect fetch to addr_i this cycle
addr_i  in  32  branch target (halfword aligned)
busy_o  out  1  any request pending or outstanding
fifo_clear_o  out  1  FIFO clear
fifo_addr_o  out  32  address loaded into FIFO on clear
fifo_valid_o  out  1  push response word into FIFO
fifo_rdata_o  out  32  pushed data
fifo_err_o  out  1  pushed bus error
fifo_busy_i  in  NUM_REQS  upper-entry occupancy from FIFO
instr_req_o  out  1  bus request
instr_gnt_i  in  1  bus grant
instr_addr_o  out  32  bus address, bits [1:0] always 0
instr_rvalid_i  in  1  response valid (in order, >=1 cycle after gnt)
instr_rdata_i  in  32  response data
instr_err_i  in  1  response error

Behaviour:
- Reset: all outputs 0, state IDLE, fetch_addr_q=0, outstanding/discard vectors cleared. Reset mid-transaction drops everything; late rvalids after reset are ignored (outstanding=0).
- fifo_clear_o=branch_i; fifo_addr_o=addr_i (combinational, 0-cycle).
- Outstanding tracking: NUM_REQS-bit thermometer outst_q plus parallel discard_q. Grant sets the lowest free bit. rvalid retires bit 0 and shifts both vectors down. Grant and rvalid in the same cycle: shift, then set.
- Space check: req_ok = popcount(outst_q & ~discard_q) + popcount(fifo_busy_i) < NUM_REQS, and outst_q[NUM_REQS-1]=0. On branch, only the second term applies (the FIFO is being cleared).
- States:
  - IDLE: instr_req_o = req_i & req_ok. Address is {addr_i[31:2],2'b00} if branch_i, else fetch_addr_q. On gnt, fetch_addr_q = issued addr+4. With no gnt, go to WAIT_GNT and latch the issued addr.
  - WAIT_GNT: instr_req_o=1, instr_addr_o held stable (no retraction, no address change). On gnt, go to IDLE and fetch_addr_q=addr+4. A branch_i in this state stores the aligned target in branch_addr_q, marks the pending request for discard, and moves to WAIT_GNT_BR.
  - WAIT_GNT_BR: request held at the old addr. On gnt the slot is set with discard=1, fetch_addr_q=branch_addr_q, and the state returns to IDLE. A further branch only overwrites branch_addr_q.
- Branch: every set outst_q bit gets discard_q=1 in the same cycle. A grant in the same cycle is for the new target, so its bit is not discarded.
- Response: on instr_rvalid_i with discard_q[0]=0, fifo_valid_o=1 with rdata/err passed through combinationally. If discard_q[0]=1, no push. An rvalid in the branch cycle is dropped.
- Bus error does not stop fetching. The FIFO and IF stage handle the error.
- Address arithmetic wraps modulo 2^32 (0xFFFFFFFC+4 -> 0).
- req_i low: no new request. An un-granted request is still held until gnt. Outstanding responses are still pushed.
- busy_o = instr_req_o | (|outst_q).
- Assertion: rvalid never arrives when outst_q=0.

Decomposition:
- ibex_pkg gets the state enum (fetch_req_state_e: IDLE, WAIT_GNT, WAIT_GNT_BR) and constant FETCH_ADDR_INCR=4.
- One natural sub-module, ibex_fetch_outst_tracker. It holds the outst_q/discard_q shift vectors and produces req_ok and the discard flag for the oldest entry.

Test Plan:
- Reset, req_i=1, branch to 0x0000_1002, gnt immediate, rvalid next cycle. Expect clear with fifo_addr_o=0x1002, bus addrs 0x1000, 0x1004, 0x1008, and pushes in order.
- fifo_busy_i=2'b11, req_i=1. Expect instr_req_o=0. Drop fifo_busy_i to 2'b01: one request issues, and no second until an rvalid retires it.
- Gnt withheld 3 cycles at 0x2000, branch to 0x3000 in cycle 2. Expect instr_addr_o stays 0x2000 until gnt, next request 0x3000, and the 0x2000 response not pushed.
- Two outstanding (0x100, 0x104), branch to 0x400 with a same-cycle grant. Expect both old responses discarded and the 0x400 response pushed.
- Response with instr_err_i=1 at 0x500. Expect fifo_valid_o=1, fifo_err_o=1, and the next request at 0x504.
- Assert rst_i with 2 outstanding, release, then drive stray rvalid. Expect no push, busy_o=0, and the next fetch from fetch_addr_q=0.

Source files
------------

// File: rtl/ibex_pkg.sv
// Shared types and constants for the instruction fetch request path.
//   fetch_req_state_e : request sequencing states of ibex_fetch_req_ctrl
//   FETCH_ADDR_INCR   : byte distance between consecutive fetch words
//   word_align()      : clears the two low address bits
package ibex_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_GNT    = 2'd1,
    WAIT_GNT_BR = 2'd2
  } fetch_req_state_e;

  localparam logic [31:0] FETCH_ADDR_INCR = 32'd4;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ibex_fetch_outst_tracker.sv
// Outstanding-transaction bookkeeping for the fetch request controller.
// Ports:
//   clk_i, rst_i       clock, asynchronous active-high reset
//   gnt_i              a request was granted this cycle
//   gnt_discard_i      the granted request's response must be dropped
//   rvalid_i           response for the oldest transaction arrives
//   branch_i           redirect: everything in flight becomes stale
//   fifo_busy_i        upper-entry occupancy of the fetch FIFO
//   req_ok_o           room for one more request
//   outst_oldest_o     oldest slot holds a live transaction
//   discard_oldest_o   oldest slot's response is to be dropped
//   outst_any_o        any transaction outstanding
module ibex_fetch_outst_tracker #(
  parameter int NUM_REQS = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                gnt_i,
  input  logic                gnt_discard_i,
  input  logic                rvalid_i,
  input  logic                branch_i,
  input  logic [NUM_REQS-1:0] fifo_busy_i,
  output logic                req_ok_o,
  output logic                outst_oldest_o,
  output logic                discard_oldest_o,
  output logic                outst_any_o
);

  // Thermometer: bit 0 is the oldest transaction. discard_q runs alongside.
  logic [NUM_REQS-1:0] outst_q, outst_d;
  logic [NUM_REQS-1:0] discard_q, discard_d;
  logic [3:0]          live_cnt, busy_cnt;
  logic                fits;
  logic                set_done;

  // Discarded transactions will never reach the FIFO, so they do not
  // consume FIFO space; a branch clears the FIFO so its occupancy is moot.
  always_comb begin
    live_cnt = '0;
    busy_cnt = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      live_cnt = live_cnt + 4'(outst_q[i] & ~discard_q[i]);
      busy_cnt = busy_cnt + 4'(fifo_busy_i[i]);
    end
    fits     = (live_cnt + busy_cnt) < 4'(NUM_REQS);
    req_ok_o = (branch_i | fits) & ~outst_q[NUM_REQS-1];
  end

  // Retire first, then mark stale on branch, then claim the lowest free slot.
  always_comb begin
    outst_d   = outst_q;
    discard_d = discard_q;
    set_done  = 1'b0;
    if (rvalid_i) begin
      outst_d   = outst_q >> 1;
      discard_d = discard_q >> 1;
    end
    if (branch_i) begin
      discard_d = discard_d | outst_d;
    end
    if (gnt_i) begin
      for (int i = 0; i < NUM_REQS; i++) begin
        if (!outst_d[i] && !set_done) begin
          outst_d[i]   = 1'b1;
          discard_d[i] = gnt_discard_i;
          set_done     = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      outst_q   <= '0;
      discard_q <= '0;
    end else begin
      outst_q   <= outst_d;
      discard_q <= discard_d;
    end
  end

  assign outst_oldest_o   = outst_q[0];
  assign discard_oldest_o = discard_q[0];
  assign outst_any_o      = |outst_q;

endmodule

// File: rtl/ibex_fetch_req_ctrl.sv
// Instruction fetch request sequencer. Issues word-aligned bus requests,
// holds un-granted requests stable, tracks in-flight transactions and
// forwards non-stale responses into the fetch FIFO.
// Handshake: a bus transfer happens when instr_req_o & instr_gnt_i at a
// rising edge; once raised, instr_req_o stays high with instr_addr_o
// unchanged until granted. Responses return in order via instr_rvalid_i.
// Ports:
//   clk_i, rst_i                   clock, asynchronous active-high reset
//   req_i, branch_i, addr_i        IF-stage fetch enable and redirect
//   busy_o                         request pending or outstanding
//   fifo_clear_o, fifo_addr_o      FIFO flush with redirect address
//   fifo_valid_o/rdata_o/err_o     FIFO push of a response word
//   fifo_busy_i                    FIFO upper-entry occupancy
//   instr_req_o/gnt_i/addr_o       bus request channel
//   instr_rvalid_i/rdata_i/err_i   bus response channel
module ibex_fetch_req_ctrl #(
  parameter int NUM_REQS = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_i,
  input  logic                branch_i,
  input  logic [31:0]         addr_i,
  output logic                busy_o,
  output logic                fifo_clear_o,
  output logic [31:0]         fifo_addr_o,
  output logic                fifo_valid_o,
  output logic [31:0]         fifo_rdata_o,
  output logic                fifo_err_o,
  input  logic [NUM_REQS-1:0] fifo_busy_i,
  output logic                instr_req_o,
  input  logic                instr_gnt_i,
  output logic [31:0]         instr_addr_o,
  input  logic                instr_rvalid_i,
  input  logic [31:0]         instr_rdata_i,
  input  logic                instr_err_i
);
  import ibex_pkg::*;

  fetch_req_state_e state_q, state_d;
  logic [31:0] fetch_addr_q, fetch_addr_d;
  logic [31:0] stored_addr_q, stored_addr_d;   // address of the held request
  logic [31:0] branch_addr_q, branch_addr_d;   // redirect waiting behind it
  logic [31:0] branch_tgt;
  logic        req_ok, req_issue, gnt_accept, gnt_discard;
  logic        outst_oldest, discard_oldest, outst_any;

  assign branch_tgt = word_align(addr_i);

  always_comb begin
    state_d       = state_q;
    fetch_addr_d  = fetch_addr_q;
    stored_addr_d = stored_addr_q;
    branch_addr_d = branch_addr_q;
    req_issue     = 1'b0;
    instr_addr_o  = stored_addr_q;
    unique case (state_q)
      IDLE: begin
        instr_addr_o = branch_i ? branch_tgt : fetch_addr_q;
        req_issue    = req_i & req_ok;
        if (req_issue) begin
          if (instr_gnt_i) begin
            fetch_addr_d = instr_addr_o + FETCH_ADDR_INCR;
          end else begin
            state_d       = WAIT_GNT;
            stored_addr_d = instr_addr_o;
          end
        end else if (branch_i) begin
          fetch_addr_d = branch_tgt;
        end
      end
      WAIT_GNT: begin
        req_issue = 1'b1;
        if (instr_gnt_i) begin
          state_d      = IDLE;
          // A branch coinciding with the grant makes this response stale.
          fetch_addr_d = branch_i ? branch_tgt : stored_addr_q + FETCH_ADDR_INCR;
        end else if (branch_i) begin
          state_d       = WAIT_GNT_BR;
          branch_addr_d = branch_tgt;
        end
      end
      WAIT_GNT_BR: begin
        req_issue = 1'b1;
        if (branch_i) begin
          branch_addr_d = branch_tgt;
        end
        if (instr_gnt_i) begin
          state_d      = IDLE;
          fetch_addr_d = branch_i ? branch_tgt : branch_addr_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      fetch_addr_q  <= '0;
      stored_addr_q <= '0;
      branch_addr_q <= '0;
    end else begin
      state_q       <= state_d;
      fetch_addr_q  <= fetch_addr_d;
      stored_addr_q <= stored_addr_d;
      branch_addr_q <= branch_addr_d;
    end
  end

  assign instr_req_o = req_issue;
  assign gnt_accept  = req_issue & instr_gnt_i;
  // Held requests granted after a redirect fetch the old address.
  assign gnt_discard = (state_q == WAIT_GNT_BR) | ((state_q == WAIT_GNT) & branch_i);

  ibex_fetch_outst_tracker #(
    .NUM_REQS(NUM_REQS)
  ) u_tracker (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .gnt_i            (gnt_accept),
    .gnt_discard_i    (gnt_discard),
    .rvalid_i         (instr_rvalid_i),
    .branch_i         (branch_i),
    .fifo_busy_i      (fifo_busy_i),
    .req_ok_o         (req_ok),
    .outst_oldest_o   (outst_oldest),
    .discard_oldest_o (discard_oldest),
    .outst_any_o      (outst_any)
  );

  assign fifo_clear_o = branch_i;
  assign fifo_addr_o  = addr_i;
  // The FIFO is being flushed in a branch cycle, so nothing is pushed then.
  assign fifo_valid_o = instr_rvalid_i & outst_oldest & ~discard_oldest & ~branch_i;
  assign fifo_rdata_o = instr_rdata_i;
  assign fifo_err_o   = instr_err_i;
  assign busy_o       = instr_req_o | outst_any;

  rvalid_needs_outstanding: assert property (
    @(posedge clk_i) disable iff (rst_i) instr_rvalid_i |-> outst_any
  );

endmodule

// File: tb/tb_ibex_fetch_req_ctrl.sv
module tb_ibex_fetch_req_ctrl;
  localparam int N = 2;

  logic clk = 1'b0;
  logic rst;
  logic req, branch, gnt, rvalid, err;
  logic [31:0] addr, rdata;
  logic [N-1:0] fifo_busy;
  logic busy_o, fifo_clear_o, fifo_valid_o, fifo_err_o, instr_req_o;
  logic [31:0] fifo_addr_o, fifo_rdata_o, instr_addr_o;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  ibex_fetch_req_ctrl #(.NUM_REQS(N)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .branch_i(branch), .addr_i(addr),
    .busy_o(busy_o), .fifo_clear_o(fifo_clear_o), .fifo_addr_o(fifo_addr_o),
    .fifo_valid_o(fifo_valid_o), .fifo_rdata_o(fifo_rdata_o), .fifo_err_o(fifo_err_o),
    .fifo_busy_i(fifo_busy), .instr_req_o(instr_req_o), .instr_gnt_i(gnt),
    .instr_addr_o(instr_addr_o), .instr_rvalid_i(rvalid), .instr_rdata_i(rdata),
    .instr_err_i(err)
  );

  // Reference model: transactions in flight, a possibly pending request
  // and the next sequential fetch address.
  typedef struct {logic [31:0] addr; bit disc;} ent_t;
  ent_t        outq[$];
  logic [31:0] bus_q[$];
  logic [31:0] m_fptr, m_pend_addr, m_redir;
  bit          m_pend, m_redir_pend;
  bit          e_req, e_push, bus_take;
  logic [31:0] e_addr, e_data, bus_addr;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  task automatic model_reset();
    outq.delete();
    bus_q.delete();
    m_fptr = 0; m_pend_addr = 0; m_redir = 0; m_pend = 0; m_redir_pend = 0;
  endtask

  task automatic predict();
    int live;
    bit ok;
    logic [31:0] tgt;
    live = 0;
    foreach (outq[i]) if (!outq[i].disc) live++;
    tgt = {addr[31:2], 2'b00};
    ok = (branch || (live + $countones(fifo_busy) < N)) && (outq.size() < N);
    if (m_pend) begin
      e_req = 1; e_addr = m_pend_addr;
    end else begin
      e_req = req && ok; e_addr = branch ? tgt : m_fptr;
    end
    e_push = rvalid && outq.size() > 0 && !outq[0].disc && !branch;
    e_data = (outq.size() > 0) ? data_of(outq[0].addr) : 32'h0;
  endtask

  task automatic model_update();
    logic [31:0] tgt;
    tgt = {addr[31:2], 2'b00};
    if (rvalid && outq.size() > 0) void'(outq.pop_front());
    if (branch) foreach (outq[i]) outq[i].disc = 1;
    if (e_req && gnt) begin
      outq.push_back('{e_addr, m_pend && (m_redir_pend || branch)});
      if (!m_pend)           m_fptr = e_addr + 32'd4;
      else if (branch)       m_fptr = tgt;
      else if (m_redir_pend) m_fptr = m_redir;
      else                   m_fptr = m_pend_addr + 32'd4;
      m_pend = 0; m_redir_pend = 0;
    end else if (e_req) begin
      if (!m_pend) begin
        m_pend = 1; m_pend_addr = e_addr;
      end else if (branch) begin
        m_redir_pend = 1; m_redir = tgt;
      end
    end else if (branch) begin
      m_fptr = tgt;
    end
  endtask

  // Drive one cycle's inputs (just after a rising edge), settle to the
  // falling edge and compute the model's expectation.
  task automatic set_in(input logic r, input logic b, input logic [31:0] a,
                        input logic g, input logic rv, input logic e,
                        input logic [N-1:0] fb);
    req = r; branch = b; addr = a; gnt = g; rvalid = rv; err = e; fifo_busy = fb;
    rdata = (rv && bus_q.size() > 0) ? data_of(bus_q[0]) : $urandom;
    @(negedge clk);
    predict();
    bus_take = instr_req_o && gnt;
    bus_addr = instr_addr_o;
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    if (rvalid && bus_q.size() > 0) void'(bus_q.pop_front());
    if (bus_take) bus_q.push_back(bus_addr);
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 8 && bus_q.size() > 0; k++) begin
      set_in(0, 0, 0, 0, 1, 0, 0);
      tick();
    end
    checks++;
    if (bus_q.size() != 0) begin
      $display("FAIL drain_timeout: %0d responses left, want 0", bus_q.size()); fails++;
    end
  endtask

  task automatic test_reset();
    rst = 1; req = 0; branch = 0; addr = 0; gnt = 0; rvalid = 0; err = 0;
    rdata = 0; fifo_busy = 0;
    model_reset();
    @(negedge clk);
    checks++; if (instr_req_o !== 1'b0) begin $display("FAIL rst_req: got %b want 0", instr_req_o); fails++; end
    checks++; if (busy_o !== 1'b0) begin $display("FAIL rst_busy: got %b want 0", busy_o); fails++; end
    checks++; if (fifo_valid_o !== 1'b0) begin $display("FAIL rst_valid: got %b want 0", fifo_valid_o); fails++; end
    checks++; if (instr_addr_o !== 32'h0) begin $display("FAIL rst_addr: got %h want 0", instr_addr_o); fails++; end
    @(posedge clk); #1;
    rst = 0;
    set_in(0, 0, 0, 0, 0, 0, 0);
    checks++; if (busy_o !== 1'b0) begin $display("FAIL post_rst_busy: got %b want 0", busy_o); fails++; end
    tick();
  endtask

  task automatic test_branch_stream();
    set_in(1, 1, 32'h0000_1002, 1, 0, 0, 0);
    checks++; if (fifo_clear_o !== 1'b1) begin $display("FAIL bs_clear: got %b want 1", fifo_clear_o); fails++; end
    checks++; if (fifo_addr_o !== 32'h1002) begin $display("FAIL bs_fifo_addr: got %h want 00001002", fifo_addr_o); fails++; end
    checks++; if (instr_addr_o !== 32'h1000 || instr_req_o !== 1'b1) begin $display("FAIL bs_addr0: got %h req %b want 00001000 req 1", instr_addr_o, instr_req_o); fails++; end
    tick();
    for (int k = 1; k <= 2; k++) begin
      set_in(1, 0, 0, 1, 1, 0, 0);
      checks++; if (instr_addr_o !== 32'h1000 + 32'(4 * k)) begin $display("FAIL bs_addr%0d: got %h want %h", k, instr_addr_o, 32'h1000 + 32'(4 * k)); fails++; end
      checks++; if (fifo_valid_o !== 1'b1 || fifo_rdata_o !== data_of(32'h1000 + 32'(4 * (k - 1)))) begin $display("FAIL bs_push%0d: got v%b %h want v1 %h", k, fifo_valid_o, fifo_rdata_o, data_of(32'h1000 + 32'(4 * (k - 1)))); fails++; end
      tick();
    end
    set_in(0, 0, 0, 0, 1, 0, 0);
    checks++; if (fifo_valid_o !== 1'b1 || fifo_rdata_o !== data_of(32'h1008)) begin $display("FAIL bs_push3: got v%b %h want v1 %h", fifo_valid_o, fifo_rdata_o, data_of(32'h1008)); fails++; end
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0);
    checks++; if (busy_o !== 1'b0) begin $display("FAIL bs_idle_busy: got %b want 0", busy_o); fails++; end
    tick();
  endtask

  task automatic test_throttle();
    set_in(1, 0, 0, 1, 0, 0, 2'b11);
    checks++; if (instr_req_o !== 1'b0) begin $display("FAIL thr_full: got %b want 0", instr_req_o); fails++; end
    tick();
    set_in(1, 0, 0, 1, 0, 0, 2'b01);
    checks++; if (instr_req_o !== 1'b1) begin $display("FAIL thr_one: got %b want 1", instr_req_o); fails++; end
    tick();
    set_in(1, 0, 0, 1, 0, 0, 2'b01);
    checks++; if (instr_req_o !== 1'b0) begin $display("FAIL thr_second: got %b want 0", instr_req_o); fails++; end
    tick();
    set_in(1, 0, 0, 1, 1, 0, 2'b01);
    checks++; if (instr_req_o !== 1'b0 || fifo_valid_o !== 1'b1) begin $display("FAIL thr_retire: got req %b v %b want req 0 v 1", instr_req_o, fifo_valid_o); fails++; end
    tick();
    set_in(1, 0, 0, 1, 0, 0, 2'b01);
    checks++; if (instr_req_o !== 1'b1) begin $display("FAIL thr_again: got %b want 1", instr_req_o); fails++; end
    tick();
    drain();
  endtask

  task automatic test_wait_gnt_branch();
    set_in(1, 1, 32'h2000, 0, 0, 0, 0);
    tick();
    set_in(1, 1, 32'h3000, 0, 0, 0, 0);
    checks++; if (instr_addr_o !== 32'h2000 || instr_req_o !== 1'b1) begin $display("FAIL wg_hold_br: got %h req %b want 00002000 req 1", instr_addr_o, instr_req_o); fails++; end
    tick();
    set_in(1, 0, 0, 0, 0, 0, 0);
    checks++; if (instr_addr_o !== 32'h2000) begin $display("FAIL wg_hold: got %h want 00002000", instr_addr_o); fails++; end
    tick();
    set_in(0, 0, 0, 1, 0, 0, 0);
    checks++; if (instr_addr_o !== 32'h2000 || instr_req_o !== 1'b1) begin $display("FAIL wg_gnt: got %h req %b want 00002000 req 1", instr_addr_o, instr_req_o); fails++; end
    tick();
    set_in(1, 0, 0, 1, 1, 0, 0);
    checks++; if (instr_addr_o !== 32'h3000) begin $display("FAIL wg_next: got %h want 00003000", instr_addr_o); fails++; end
    checks++; if (fifo_valid_o !== 1'b0) begin $display("FAIL wg_stale: got %b want 0", fifo_valid_o); fails++; end
    tick();
    set_in(0, 0, 0, 0, 1, 0, 0);
    checks++; if (fifo_valid_o !== 1'b1 || fifo_rdata_o !== data_of(32'h3000)) begin $display("FAIL wg_push: got v%b %h want v1 %h", fifo_valid_o, fifo_rdata_o, data_of(32'h3000)); fails++; end
    tick();
  endtask

  task automatic test_branch_outstanding();
    set_in(1, 1, 32'h100, 1, 0, 0, 0); tick();
    set_in(1, 0, 0, 1, 0, 0, 0); tick();
    set_in(1, 1, 32'h400, 1, 0, 0, 0);
    checks++; if (instr_req_o !== 1'b0 || busy_o !== 1'b1) begin $display("FAIL bo_full: got req %b busy %b want req 0 busy 1", instr_req_o, busy_o); fails++; end
    tick();
    set_in(1, 0, 0, 1, 1, 0, 0);
    checks++; if (fifo_valid_o !== 1'b0) begin $display("FAIL bo_drop0: got %b want 0", fifo_valid_o); fails++; end
    tick();
    set_in(1, 0, 0, 1, 1, 0, 0);
    checks++; if (fifo_valid_o !== 1'b0 || instr_addr_o !== 32'h400 || instr_req_o !== 1'b1) begin $display("FAIL bo_drop1: got v%b %h req %b want v0 00000400 req 1", fifo_valid_o, instr_addr_o, instr_req_o); fails++; end
    tick();
    set_in(0, 0, 0, 0, 1, 0, 0);
    checks++; if (fifo_valid_o !== 1'b1 || fifo_rdata_o !== data_of(32'h400)) begin $display("FAIL bo_push: got v%b %h want v1 %h", fifo_valid_o, fifo_rdata_o, data_of(32'h400)); fails++; end
    tick();
    // Branch with a same-cycle grant: the granted word is the new target.
    set_in(1, 1, 32'h600, 1, 0, 0, 0); tick();
    set_in(1, 1, 32'h702, 1, 0, 0, 0);
    checks++; if (instr_addr_o !== 32'h700 || instr_req_o !== 1'b1) begin $display("FAIL bo_same_gnt: got %h req %b want 00000700 req 1", instr_addr_o, instr_req_o); fails++; end
    tick();
    set_in(0, 0, 0, 0, 1, 0, 0);
    checks++; if (fifo_valid_o !== 1'b0) begin $display("FAIL bo_drop600: got %b want 0", fifo_valid_o); fails++; end
    tick();
    set_in(0, 0, 0, 0, 1, 0, 0);
    checks++; if (fifo_valid_o !== 1'b1 || fifo_rdata_o !== data_of(32'h700)) begin $display("FAIL bo_push700: got v%b %h want v1 %h", fifo_valid_o, fifo_rdata_o, data_of(32'h700)); fails++; end
    tick();
  endtask

  task automatic test_bus_error();
    set_in(1, 1, 32'h500, 1, 0, 0, 0); tick();
    set_in(1, 0, 0, 1, 1, 1, 0);
    checks++; if (fifo_valid_o !== 1'b1 || fifo_err_o !== 1'b1) begin $display("FAIL err_push: got v%b e%b want v1 e1", fifo_valid_o, fifo_err_o); fails++; end
    checks++; if (instr_addr_o !== 32'h504 || instr_req_o !== 1'b1) begin $display("FAIL err_next: got %h req %b want 00000504 req 1", instr_addr_o, instr_req_o); fails++; end
    tick();
    drain();
  endtask

  task automatic test_wrap();
    set_in(1, 1, 32'hFFFF_FFFE, 1, 0, 0, 0);
    checks++; if (instr_addr_o !== 32'hFFFF_FFFC) begin $display("FAIL wrap_top: got %h want fffffffc", instr_addr_o); fails++; end
    tick();
    set_in(1, 0, 0, 1, 0, 0, 0);
    checks++; if (instr_addr_o !== 32'h0) begin $display("FAIL wrap_zero: got %h want 00000000", instr_addr_o); fails++; end
    tick();
    drain();
  endtask

  task automatic test_reset_midflight();
    set_in(1, 1, 32'h800, 1, 0, 0, 0); tick();
    set_in(1, 0, 0, 1, 0, 0, 0); tick();
    rst = 1; req = 0; branch = 0; gnt = 0; rvalid = 1; err = 0; rdata = 32'hDEAD_BEEF;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++; if (fifo_valid_o !== 1'b0 || busy_o !== 1'b0) begin $display("FAIL mr_stray%0d: got v%b busy %b want v0 busy 0", k, fifo_valid_o, busy_o); fails++; end
      @(posedge clk); #1;
    end
    rst = 0; rvalid = 0;
    set_in(1, 0, 0, 1, 0, 0, 0);
    checks++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h0) begin $display("FAIL mr_restart: got req %b %h want req 1 00000000", instr_req_o, instr_addr_o); fails++; end
    tick();
    drain();
  endtask

  task automatic test_random();
    logic r, b, g, rv, e;
    logic [N-1:0] fb;
    logic [31:0] a;
    for (int c = 0; c < 2000; c++) begin
      r  = ($urandom_range(0, 4) != 0);
      b  = ($urandom_range(0, 11) == 0);
      a  = $urandom;
      g  = ($urandom_range(0, 4) < 3);
      rv = (bus_q.size() > 0) && ($urandom_range(0, 2) != 0);
      e  = $urandom_range(0, 1);
      fb = N'($urandom_range(0, (1 << N) - 1));
      set_in(r, b, a, g, rv, e, fb);
      checks++; if (instr_req_o !== e_req) begin $display("FAIL rnd_req c%0d: got %b want %b", c, instr_req_o, e_req); fails++; end
      if (e_req) begin
        checks++; if (instr_addr_o !== e_addr) begin $display("FAIL rnd_addr c%0d: got %h want %h", c, instr_addr_o, e_addr); fails++; end
      end
      checks++; if (fifo_valid_o !== e_push) begin $display("FAIL rnd_push c%0d: got %b want %b", c, fifo_valid_o, e_push); fails++; end
      if (e_push) begin
        checks++; if (fifo_rdata_o !== e_data || fifo_err_o !== e) begin $display("FAIL rnd_data c%0d: got %h e%b want %h e%b", c, fifo_rdata_o, fifo_err_o, e_data, e); fails++; end
      end
      checks++; if (busy_o !== (e_req || outq.size() > 0)) begin $display("FAIL rnd_busy c%0d: got %b want %b", c, busy_o, (e_req || outq.size() > 0)); fails++; end
      checks++; if (fifo_clear_o !== b || fifo_addr_o !== a) begin $display("FAIL rnd_clear c%0d: got %b %h want %b %h", c, fifo_clear_o, fifo_addr_o, b, a); fails++; end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_branch_stream();
    test_throttle();
    test_wait_gnt_branch();
    test_branch_outstanding();
    test_bus_error();
    test_wrap();
    test_reset_midflight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
